// File: rtl/fmsched_pkg.sv
// fmsched_pkg: shared types and constants for the freemachine scheduler.
//   - state_e      : scheduler FSM states
//   - PASS_CNT_W   : width of the pass counter
//   - IDX_W        : width of a machine index (supports up to 8 machines)
//   - *_W          : memory field widths, taken from the bank-interface macros
// The bank-interface width macros get defaults here when the build does not supply them.

`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 14
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 10
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 32
`endif

package fmsched_pkg;

    localparam int unsigned PASS_CNT_W  = 16;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned BANK_ADDR_W = `BANK_ADDR_WIDTH;
    localparam int unsigned COL_ADDR_W  = `COL_ADDR_WIDTH;
    localparam int unsigned TX_DATA_W   = `TX_DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StRun,
        StEval,
        StFinish
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N_REQ requesters.
//   i_clk, i_reset : clock, synchronous active-high reset (pointer returns to 0)
//   i_req          : request vector
//   i_advance      : a transfer completed; move pointer to i_adv_idx+1 mod N_REQ
//   i_adv_idx      : index of the machine whose transfer completed
//   o_grant        : one-hot grant for the highest-priority requester (0 if none)

module rr_arbiter
    import fmsched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_req,
    input  logic               i_advance,
    input  logic [IDX_W-1:0]   i_adv_idx,
    output logic [N_REQ-1:0]   o_grant
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_valid;
    int               w_dist;
    int               w_best;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            if (32'(i_adv_idx) + 32'd1 >= N_REQ) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= i_adv_idx + 1'b1;
            end
        end
    end

    // Pick the requester with the smallest circular distance from the pointer.
    always_comb begin
        w_sel_idx   = '0;
        w_sel_valid = 1'b0;
        w_dist      = 0;
        w_best      = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (i_req[i]) begin
                if (i >= int'(r_ptr)) begin
                    w_dist = i - int'(r_ptr);
                end else begin
                    w_dist = i + int'(N_REQ) - int'(r_ptr);
                end
                if (!w_sel_valid || w_dist < w_best) begin
                    w_best      = w_dist;
                    w_sel_valid = 1'b1;
                    w_sel_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            o_grant[i] = w_sel_valid && (w_sel_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/freemachine_sched.sv
// freemachine_sched: runs passes over N_MACH freemachine instances, arbitrating
// their shared memory-bank accesses, until no machine reports a change or the
// pass limit is reached.
//   Control : i_clk, i_reset (sync, active-high), i_start (pulse, honoured in IDLE)
//   Machines: i_m_read_en/i_m_write_en/i_m_row_addr/i_m_col_addr/i_m_wdata requests,
//             i_m_done/i_m_changed/i_m_updates status; o_m_ack, o_m_rdata, o_sync_out
//   Bank    : o_mem_rd_en/o_mem_wr_en/o_mem_row/o_mem_col/o_mem_wdata, i_mem_ack, i_mem_rdata
//   Status  : o_busy, o_finished, o_limit_hit, o_pass_count, o_total_updates
// Build option FMSCHED_STATS_EN: when defined, o_total_updates latches the summed
// prune count at FINISH; otherwise it is tied to 0 and the adder is not built.

module freemachine_sched
    import fmsched_pkg::*;
#(
    parameter int unsigned N_MACH     = 4,
    parameter int unsigned MAX_PASSES = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [N_MACH-1:0]             i_m_read_en,
    input  logic [N_MACH-1:0]             i_m_write_en,
    input  logic [N_MACH*BANK_ADDR_W-1:0] i_m_row_addr,
    input  logic [N_MACH*COL_ADDR_W-1:0]  i_m_col_addr,
    input  logic [N_MACH*TX_DATA_W-1:0]   i_m_wdata,
    input  logic [N_MACH-1:0]             i_m_done,
    input  logic [N_MACH-1:0]             i_m_changed,
    input  logic [N_MACH*32-1:0]          i_m_updates,
    output logic [N_MACH-1:0]             o_m_ack,
    output logic [TX_DATA_W-1:0]          o_m_rdata,
    output logic                          o_sync_out,
    output logic                          o_mem_rd_en,
    output logic                          o_mem_wr_en,
    output logic [BANK_ADDR_W-1:0]        o_mem_row,
    output logic [COL_ADDR_W-1:0]         o_mem_col,
    output logic [TX_DATA_W-1:0]          o_mem_wdata,
    input  logic                          i_mem_ack,
    input  logic [TX_DATA_W-1:0]          i_mem_rdata,
    output logic                          o_busy,
    output logic                          o_finished,
    output logic                          o_limit_hit,
    output logic [PASS_CNT_W-1:0]         o_pass_count,
    output logic [31:0]                   o_total_updates
);

    state_e                r_state;
    state_e                w_state_next;
    logic [N_MACH-1:0]     r_grant;
    logic                  r_sync;
    logic [PASS_CNT_W-1:0] r_pass_count;
    logic                  r_finished;
    logic                  r_limit_hit;

    logic [N_MACH-1:0]     w_req;
    logic [N_MACH-1:0]     w_arb_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_grant_valid;
    logic                  w_gnt_rd;
    logic                  w_gnt_wr;
    logic                  w_run;
    logic                  w_all_done;
    logic                  w_any_changed;
    logic                  w_below_limit;
    logic                  w_load_grant;
    logic                  w_xfer_done;

    assign w_req         = i_m_read_en | i_m_write_en;
    assign w_run         = (r_state == StRun);
    assign w_grant_valid = |r_grant;
    assign w_all_done    = &i_m_done;
    assign w_any_changed = |i_m_changed;
    assign w_below_limit = (32'(r_pass_count) < MAX_PASSES);
    assign w_xfer_done   = w_run && w_grant_valid && i_mem_ack;
    // No new grant once every machine is done; RUN hands over to EVAL instead.
    assign w_load_grant  = w_run && !w_grant_valid && !w_all_done && (|w_arb_grant);

    rr_arbiter #(
        .N_REQ (N_MACH)
    ) u_arb (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (w_req),
        .i_advance (w_xfer_done),
        .i_adv_idx (w_grant_idx),
        .o_grant   (w_arb_grant)
    );

    // Granted machine's request fields; all zero while nothing is granted.
    always_comb begin
        w_grant_idx = '0;
        w_gnt_rd    = 1'b0;
        w_gnt_wr    = 1'b0;
        o_mem_row   = '0;
        o_mem_col   = '0;
        o_mem_wdata = '0;
        for (int i = 0; i < int'(N_MACH); i++) begin
            if (r_grant[i]) begin
                w_grant_idx = IDX_W'(i);
                w_gnt_rd    = i_m_read_en[i];
                w_gnt_wr    = i_m_write_en[i];
                o_mem_row   = i_m_row_addr[i*BANK_ADDR_W +: BANK_ADDR_W];
                o_mem_col   = i_m_col_addr[i*COL_ADDR_W +: COL_ADDR_W];
                o_mem_wdata = i_m_wdata[i*TX_DATA_W +: TX_DATA_W];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_next = StSync;
            StSync:   w_state_next = StRun;
            StRun:    if (w_all_done && !w_grant_valid) w_state_next = StEval;
            StEval:   w_state_next = (w_any_changed && w_below_limit) ? StSync : StFinish;
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_sync       <= 1'b0;
            r_pass_count <= '0;
            r_finished   <= 1'b0;
            r_limit_hit  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && i_start) begin
                r_finished   <= 1'b0;
                r_limit_hit  <= 1'b0;
                r_pass_count <= '0;
            end
            if (r_state == StSync) begin
                r_sync       <= ~r_sync;
                r_pass_count <= r_pass_count + 1'b1;
            end
            // Leaving EVAL with a change still pending can only mean the limit stopped us.
            if (r_state == StEval && w_state_next == StFinish) begin
                r_finished  <= 1'b1;
                r_limit_hit <= w_any_changed;
            end
            if (w_load_grant) begin
                r_grant <= w_arb_grant;
            end else if (w_xfer_done || (w_grant_valid && !(w_gnt_rd || w_gnt_wr))) begin
                r_grant <= '0;
            end
        end
    end

`ifdef FMSCHED_STATS_EN
    logic [31:0] r_total_updates;
    logic [31:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < int'(N_MACH); i++) begin
            w_sum = w_sum + i_m_updates[i*32 +: 32];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_total_updates <= '0;
        end else if (r_state == StFinish) begin
            r_total_updates <= w_sum;
        end
    end

    assign o_total_updates = r_total_updates;
`else
    logic w_unused_updates;
    assign w_unused_updates = ^i_m_updates;
    assign o_total_updates  = '0;
`endif

    assign o_m_ack      = w_xfer_done ? r_grant : '0;
    assign o_m_rdata    = i_mem_rdata;
    // Write wins when a machine raises both strobes.
    assign o_mem_wr_en  = w_run && w_gnt_wr;
    assign o_mem_rd_en  = w_run && w_gnt_rd && !w_gnt_wr;
    assign o_sync_out   = r_sync;
    assign o_busy       = (r_state == StSync) || (r_state == StRun) || (r_state == StEval);
    assign o_finished   = r_finished;
    assign o_limit_hit  = r_limit_hit;
    assign o_pass_count = r_pass_count;

endmodule

// File: tb/tb_freemachine_sched.sv
// tb_freemachine_sched: directed self-checking bench for freemachine_sched
// (N_MACH=4, MAX_PASSES=3).

module tb_freemachine_sched;
    import fmsched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned BW = BANK_ADDR_W;
    localparam int unsigned CW = COL_ADDR_W;
    localparam int unsigned DW = TX_DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N-1:0]      m_read_en, m_write_en, m_done, m_changed;
    logic [N*BW-1:0]   m_row_addr;
    logic [N*CW-1:0]   m_col_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*32-1:0]   m_updates;
    logic [N-1:0]      m_ack;
    logic [DW-1:0]     m_rdata;
    logic              sync_out, mem_rd_en, mem_wr_en;
    logic [BW-1:0]     mem_row;
    logic [CW-1:0]     mem_col;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;
    logic              busy, finished, limit_hit;
    logic [15:0]       pass_count;
    logic [31:0]       total_updates;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    freemachine_sched #(
        .N_MACH     (N),
        .MAX_PASSES (3)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_m_read_en     (m_read_en),
        .i_m_write_en    (m_write_en),
        .i_m_row_addr    (m_row_addr),
        .i_m_col_addr    (m_col_addr),
        .i_m_wdata       (m_wdata),
        .i_m_done        (m_done),
        .i_m_changed     (m_changed),
        .i_m_updates     (m_updates),
        .o_m_ack         (m_ack),
        .o_m_rdata       (m_rdata),
        .o_sync_out      (sync_out),
        .o_mem_rd_en     (mem_rd_en),
        .o_mem_wr_en     (mem_wr_en),
        .o_mem_row       (mem_row),
        .o_mem_col       (mem_col),
        .o_mem_wdata     (mem_wdata),
        .i_mem_ack       (mem_ack),
        .i_mem_rdata     (mem_rdata),
        .o_busy          (busy),
        .o_finished      (finished),
        .o_limit_hit     (limit_hit),
        .o_pass_count    (pass_count),
        .o_total_updates (total_updates)
    );

    function automatic logic [BW-1:0] row_of(input int m);
        return BW'(32'h10 + m);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        m_read_en = '0; m_write_en = '0; m_done = '0; m_changed = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, sync_out, finished, limit_hit} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {busy, sync_out, finished, limit_hit});
        else n_pass++;
        n_checks++;
        if (pass_count !== 16'd0) $display("FAIL reset_pass_count got %0d want 0", pass_count);
        else n_pass++;
        n_checks++;
        if (total_updates !== 32'd0) $display("FAIL reset_total got %0d want 0", total_updates);
        else n_pass++;
        // Requests and a stray bank ack in IDLE must not reach the bank or the machines.
        m_read_en = 4'hF; m_write_en = 4'h2; mem_ack = 1'b1;
        #1;
        n_checks++;
        if ({m_ack, mem_rd_en, mem_wr_en} !== 6'b0) $display("FAIL idle_quiet got ack=%b rd=%b wr=%b want 0", m_ack, mem_rd_en, mem_wr_en);
        else n_pass++;
        m_read_en = '0; m_write_en = '0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        int exp_seq[4];
        int n_gr;
        int age;
        exp_seq = '{1, 3, 1, 3};
        do_reset();
        m_read_en = 4'b1010; m_write_en = 4'b1000;
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_in_sync got %b want 1", busy);
        else n_pass++;
        n_gr = 0; age = 0;
        for (int cyc = 0; cyc < 60 && n_gr < 4; cyc++) begin
            if (mem_rd_en || mem_wr_en) age++;
            else age = 0;
            if (age == 1) begin
                n_checks++;
                if (mem_row !== row_of(exp_seq[n_gr])) $display("FAIL grant_row[%0d] got %h want %h", n_gr, mem_row, row_of(exp_seq[n_gr]));
                else n_pass++;
                n_checks++;
                if ({mem_rd_en, mem_wr_en} !== ((exp_seq[n_gr] == 3) ? 2'b01 : 2'b10)) $display("FAIL rd_wr[%0d] got %b%b want %b", n_gr, mem_rd_en, mem_wr_en, (exp_seq[n_gr] == 3) ? 2'b01 : 2'b10);
                else n_pass++;
            end
            if (age == 3) begin
                mem_ack = 1'b1; mem_rdata = DW'(32'hC0DE_0000 + n_gr);
                #1;
                n_checks++;
                if (m_ack !== (N'(1) << exp_seq[n_gr])) $display("FAIL m_ack[%0d] got %b want %b", n_gr, m_ack, N'(1) << exp_seq[n_gr]);
                else n_pass++;
                n_checks++;
                if (m_rdata !== DW'(32'hC0DE_0000 + n_gr)) $display("FAIL m_rdata[%0d] got %h want %h", n_gr, m_rdata, DW'(32'hC0DE_0000 + n_gr));
                else n_pass++;
                n_gr++;
            end else if (m_ack !== '0) begin
                n_checks++;
                $display("FAIL stray_m_ack got %b want 0000", m_ack);
            end
            tick();
            mem_ack = 1'b0;
        end
        n_checks++;
        if (n_gr != 4) $display("FAIL arb_grants got %0d want 4", n_gr);
        else n_pass++;
        m_read_en = '0; m_write_en = '0;
    endtask

    task automatic test_passes();
        int toggles;
        logic prev;
        do_reset();
        m_done = 4'hF; m_changed = 4'b0010;
        m_updates = {32'd5, 32'd0, 32'd7, 32'd1};
        pulse_start();
        toggles = 0; prev = sync_out;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            if (sync_out !== prev) toggles++;
            prev = sync_out;
            if (toggles == 2) m_changed = 4'b0000;
            tick();
        end
        n_checks++;
        if ({finished, busy} !== 2'b10) $display("FAIL finish_state got fin=%b busy=%b want fin=1 busy=0", finished, busy);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (toggles != 2) $display("FAIL sync_toggles got %0d want 2", toggles);
        else n_pass++;
        n_checks++;
        if (pass_count !== 16'd2) $display("FAIL pass_count got %0d want 2", pass_count);
        else n_pass++;
        n_checks++;
        if ({finished, limit_hit, sync_out} !== 3'b100) $display("FAIL done_flags got fin=%b lim=%b sync=%b want 1,0,0", finished, limit_hit, sync_out);
        else n_pass++;
        n_checks++;
`ifdef FMSCHED_STATS_EN
        if (total_updates !== 32'd13) $display("FAIL total_updates got %0d want 13", total_updates);
`else
        if (total_updates !== 32'd0) $display("FAIL total_updates got %0d want 0", total_updates);
`endif
        else n_pass++;
    endtask

    task automatic test_limit();
        int toggles;
        logic prev;
        do_reset();
        m_done = 4'hF; m_changed = 4'b0001;
        pulse_start();
        toggles = 0; prev = sync_out;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            if (sync_out !== prev) toggles++;
            prev = sync_out;
            tick();
        end
        n_checks++;
        if ({finished, limit_hit} !== 2'b11) $display("FAIL limit_flags got fin=%b lim=%b want 1,1", finished, limit_hit);
        else n_pass++;
        n_checks++;
        if (pass_count !== 16'd3 || toggles != 3) $display("FAIL limit_passes got count=%0d toggles=%0d want 3,3", pass_count, toggles);
        else n_pass++;
        tick();
        m_changed = 4'b0000;
        pulse_start();
        n_checks++;
        if ({finished, limit_hit} !== 2'b00) $display("FAIL restart_clear got fin=%b lim=%b want 0,0", finished, limit_hit);
        else n_pass++;
        for (int cyc = 0; cyc < 20 && !finished; cyc++) tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int age;
        int stage;
        logic found;
        do_reset();
        m_read_en = 4'b0100;
        pulse_start();
        age = 0; stage = 0;
        // First transfer to machine 2 completes (pointer -> 3); reset lands mid second grant.
        for (int cyc = 0; cyc < 60 && stage < 2; cyc++) begin
            if (mem_rd_en) age++;
            else age = 0;
            if (stage == 0 && age == 3) begin
                mem_ack = 1'b1; stage = 1;
                tick();
                mem_ack = 1'b0;
            end else if (stage == 1 && age == 1) begin
                stage = 2;
            end else begin
                tick();
            end
        end
        n_checks++;
        if (stage != 2) $display("FAIL mid_grant_seen got stage %0d want 2", stage);
        else n_pass++;
        reset = 1'b1; m_read_en = 4'hF;
        tick();
        mem_ack = 1'b1;
        #1;
        n_checks++;
        if ({busy, mem_rd_en, mem_wr_en, sync_out, m_ack} !== 8'b0) $display("FAIL mid_reset got busy=%b rd=%b wr=%b sync=%b ack=%b want all 0", busy, mem_rd_en, mem_wr_en, sync_out, m_ack);
        else n_pass++;
        n_checks++;
        if (pass_count !== 16'd0) $display("FAIL mid_reset_count got %0d want 0", pass_count);
        else n_pass++;
        mem_ack = 1'b0; reset = 1'b0;
        tick();
        pulse_start();
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (mem_rd_en) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || mem_row !== row_of(0)) $display("FAIL ptr_restart got found=%b row=%h want row %h", found, mem_row, row_of(0));
        else n_pass++;
        m_read_en = '0;
    endtask

    task automatic test_withdraw();
        logic found;
        do_reset();
        m_read_en = 4'b0011;
        pulse_start();
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (mem_rd_en) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || mem_row !== row_of(0)) $display("FAIL wd_first got found=%b row=%h want %h", found, mem_row, row_of(0));
        else n_pass++;
        m_read_en[0] = 1'b0;
        #1;
        n_checks++;
        if ({mem_rd_en, m_ack} !== 5'b0) $display("FAIL wd_drop got rd=%b ack=%b want 0", mem_rd_en, m_ack);
        else n_pass++;
        tick();
        n_checks++;
        if ({mem_rd_en, m_ack} !== 5'b0) $display("FAIL wd_gap got rd=%b ack=%b want 0", mem_rd_en, m_ack);
        else n_pass++;
        tick();
        n_checks++;
        if (mem_rd_en !== 1'b1 || mem_row !== row_of(1)) $display("FAIL wd_next got rd=%b row=%h want 1,%h", mem_rd_en, mem_row, row_of(1));
        else n_pass++;
        mem_ack = 1'b1;
        #1;
        n_checks++;
        if (m_ack !== 4'b0010) $display("FAIL wd_ack got %b want 0010", m_ack);
        else n_pass++;
        tick();
        mem_ack = 1'b0; m_read_en = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        m_read_en = '0; m_write_en = '0; m_done = '0; m_changed = '0; m_updates = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < int'(N); i++) begin
            m_row_addr[i*BW +: BW] = row_of(i);
            m_col_addr[i*CW +: CW] = CW'(32'h20 + i);
            m_wdata[i*DW +: DW]    = DW'(32'hA000_0000 + i);
        end
        test_reset();
        test_arbitration();
        test_passes();
        test_limit();
        test_reset_mid();
        test_withdraw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freemachine_sched.md
FREEMACHINE_SCHED -- requirements
Module: freemachine_sched

Interface
REQ-001 Parameter N_MACH, default 4, number of attached freemachine instances (1..8).
REQ-002 Parameter MAX_PASSES, default 1024, pass limit before forced finish.
REQ-003 clock  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a run when IDLE, ignored otherwise.
REQ-006 m_read_en, m_write_en  input  N_MACH  per-machine memory read/write requests.
REQ-007 m_row_addr  input  N_MACH x `BANK_ADDR_WIDTH  per-machine row address.
REQ-008 m_col_addr  input  N_MACH x `COL_ADDR_WIDTH  per-machine column address.
REQ-009 m_wdata  input  N_MACH x `TX_DATA_WIDTH  per-machine write data.
REQ-010 m_done, m_changed  input  N_MACH  per-machine pass-complete and pass-modified flags.
REQ-011 m_updates  input  N_MACH x 32  per-machine cumulative prune count.
REQ-012 m_ack  output  N_MACH  one-hot transfer acknowledge to the granted machine.
REQ-013 m_rdata  output  `TX_DATA_WIDTH  read data broadcast to all machines.
REQ-014 sync_out  output  1  pass-start toggle driven to every machine's sync_in.
REQ-015 mem_rd_en, mem_wr_en  output  1  bank request; mem_row, mem_col, mem_wdata outputs carry the granted machine's fields.
REQ-016 mem_ack, mem_rdata  input  1 / `TX_DATA_WIDTH  bank acknowledge and read data.
REQ-017 busy, finished, limit_hit  output  1  run status.
REQ-018 pass_count  output  16  passes started; total_updates  output  32  summed prune count.

Function
REQ-019 FSM states IDLE, SYNC, RUN, EVAL, FINISH; reset state IDLE.
REQ-020 IDLE->SYNC on start; finished and limit_hit clear on that transition.
REQ-021 SYNC lasts one cycle, inverts sync_out, increments pass_count, then goes to RUN.
REQ-022 RUN: when no grant is outstanding, a round-robin arbiter selects among machines with m_read_en|m_write_en; the grant register loads at the next edge.
REQ-023 Round-robin pointer starts at machine 0 after reset; after each mem_ack it moves to granted index+1, mod N_MACH.
REQ-024 While a grant is held, mem_rd_en/mem_wr_en mirror the granted machine's m_read_en/m_write_en; if both are high, write wins.
REQ-025 mem_ack is forwarded combinationally to m_ack[granted]; m_rdata = mem_rdata combinationally.
REQ-026 The grant clears at the edge after mem_ack; at least one idle cycle occurs between grants.
REQ-027 If the granted machine drops both requests before mem_ack, the grant clears next cycle with no m_ack.
REQ-028 RUN->EVAL when all m_done are high and no grant is outstanding.
REQ-029 EVAL (one cycle): if any m_changed and pass_count < MAX_PASSES, go to SYNC; else go to FINISH.
REQ-030 At EVAL->FINISH, limit_hit is set if the exit was caused by pass_count reaching MAX_PASSES with a change pending.
REQ-031 FINISH: finished=1, total_updates latches the sum of m_updates with 32-bit wrap, then return to IDLE; finished and total_updates hold until the next start.
REQ-032 busy=1 in SYNC, RUN and EVAL.
REQ-033 m_ack bits are 0 and mem_* requests are 0 outside RUN.

Reset
REQ-034 Reset has priority in any state, including mid-transfer.
REQ-035 Reset drops the grant and forces state IDLE, sync_out=0, pass_count=0, total_updates=0, busy=0, finished=0, limit_hit=0, round-robin pointer=0.

Configuration
REQ-036 When macro FMSCHED_STATS_EN is defined: pass_count and total_updates behave as specified.
REQ-037 When FMSCHED_STATS_EN is undefined: total_updates is tied to 0 and its adder is removed; pass_count is kept internally for the limit but still driven.

Structure
REQ-038 Package fmsched_pkg holds the FSM state enum and the pass_count width constant.
REQ-039 Arbitration is a sub-module rr_arbiter (request vector in, one-hot grant out, pointer advance input).

Verification
REQ-040 N_MACH=4, machines 1 and 3 requesting continuously, mem_ack 2 cycles after request -> grants alternate 1,3,1,3; m_ack only to the granted machine.
REQ-041 Pass 1 ends with m_changed=0010 and pass 2 with 0000 -> sync_out toggles twice; finished with pass_count=2.
REQ-042 m_updates={5,0,7,1} at final EVAL -> total_updates=13 (0 with FMSCHED_STATS_EN undefined).
REQ-043 MAX_PASSES=3 with m_changed always 1 -> after 3 passes finished=1 and limit_hit=1.
REQ-044 Reset asserted while a grant waits for mem_ack -> next cycle IDLE, mem_rd_en=0, sync_out=0, pointer restarts at 0.
REQ-045 Granted machine withdraws its request before mem_ack -> grant clears, no m_ack, next requester is served.
